led_anim_sequencer: RTL
=======================

// Module: led_anim_sequencer
// PURPOSE
//  Frame sequencer for the LED animation path. Produces the 5-bit frame index that
//  drives the per-digit pattern decoders (index -> 7-bit active-low segment pattern).
//  A prescaler sets the frame rate. Supports one-shot play, looped play, pause and stop.
//  Sits between the board clock/buttons and the decoder bank; the decoders stay combinational.
// PARAMETERS
//  TICK_DIV    25_000_000  clk cycles per frame (>=2); 0.5 s at 50 MHz
//  LAST_FRAME  14          last animated frame index (1..31); frames above it are blank
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  start      in   1  level sampled each clk; restart animation from frame 0
//  stop       in   1  abort to IDLE; has priority over start and pause
//  pause      in   1  level; while 1 in RUN, the prescaler and frame hold
//  loop_en    in   1  1 = wrap after LAST_FRAME; 0 = one-shot, finish in DONE
//  frame      out  5  frame index to decoders (registered)
//  frame_tick out  1  1-cycle pulse in the cycle frame changes due to the prescaler
//  busy       out  1  1 in RUN or PAUSE
//  done       out  1  1-cycle pulse on the cycle the sequencer enters DONE
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, frame=0, prescaler=0. Outputs frame_tick, busy and done are 0.
//  - States: IDLE, RUN, PAUSE, DONE. All outputs are registered; no combinational input->output path.
//  - Priority per cycle: stop > start > pause > prescaler advance.
//  - stop=1 in any state: next state IDLE; frame=0, prescaler=0, no done pulse.
//  - IDLE: frame holds 0. start=1 -> RUN with frame=0 and prescaler=0.
//  - RUN: when pause=0, prescaler counts 0..TICK_DIV-1.
//      At TICK_DIV-1, the prescaler goes to 0 and a tick occurs.
//      Tick with frame<LAST_FRAME: frame+1, frame_tick=1.
//      Tick with frame==LAST_FRAME and loop_en=1: frame=0, frame_tick=1.
//      Tick with frame==LAST_FRAME and loop_en=0: state DONE, frame holds LAST_FRAME,
//        done=1 for one cycle, frame_tick=0.
//    So each frame is displayed for exactly TICK_DIV cycles, including frame 0 after start.
//  - RUN with pause=1 -> PAUSE. The prescaler does not advance in that cycle.
//  - PAUSE with pause=0 -> RUN. The prescaler resumes from its held value, so the
//    partial frame time is preserved.
//  - start=1 in RUN, PAUSE or DONE: restart with frame=0, prescaler=0, state RUN.
//    start overrides pause for that cycle.
//  - DONE: frame holds LAST_FRAME and busy=0 until start or stop.
//  - loop_en is sampled only at the wrap tick; changing it mid-frame has no other effect.
//  - Widths: prescaler is $clog2(TICK_DIV) bits. frame never exceeds LAST_FRAME.
//  - Mid-operation reset returns to the reset values immediately (async), regardless of clk.
// CONFIGURATION
//  LED_ANIM_PINGPONG_EN defined:
//    - A direction register is added; it resets to up.
//    - With loop_en=1, a tick at LAST_FRAME while counting up reverses direction: frame
//      goes to LAST_FRAME-1, counting down.
//    - A tick at frame 0 while counting down reverses direction: frame goes to 1.
//    - start or stop resets the direction to up.
//    - One-shot (loop_en=0) behaviour is unchanged.
//  LED_ANIM_PINGPONG_EN undefined:
//    - No direction register; loop wraps LAST_FRAME -> 0 as described above.
// TESTING (bench: TICK_DIV=4, LAST_FRAME=3)
//  1. rst=1 pulse, mid-cycle -> frame=0, busy=0, done=0, frame_tick=0 immediately.
//  2. start=1 for 1 cycle, loop_en=0 -> frame is 0,1,2,3, each held 4 cycles.
//     Then done=1 for one cycle, busy=0, frame stays 3.
//  3. loop_en=1, start -> frame sequence 0,1,2,3,0,1 at 4-cycle spacing.
//     frame_tick pulses at each change; done is never set.
//  4. Mid-RUN at frame 2 after 1 prescaler cycle, pause=1 for 6 cycles -> frame stays 2.
//     After release, frame=3 exactly 3 cycles later.
//  5. RUN at frame 2 with stop=1 and start=1 in the same cycle -> next state IDLE, frame=0,
//     busy=0. Separately, rst asserted mid-frame -> all outputs return to reset values.
//  6. With LED_ANIM_PINGPONG_EN, loop_en=1 -> frame sequence 0,1,2,3,2,1,0,1,2.
//     Without the macro -> 0,1,2,3,0,1,2.

Source files
------------

// File: rtl/led_anim_sequencer.sv
// LED animation frame sequencer.
// Steps a 5-bit frame index from 0 to LAST_FRAME at one frame every TICK_DIV
// clocks, with one-shot, looped, paused and stopped operation. Every output
// is registered, so no input reaches an output combinationally.
// Optional build macro: LED_ANIM_PINGPONG_EN. When defined, looped play
// bounces between 0 and LAST_FRAME instead of wrapping back to 0.
module led_anim_sequencer #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int LAST_FRAME = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  output logic [4:0] frame,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);

  localparam int             PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [4:0]     LAST     = 5'(LAST_FRAME);
`ifdef LED_ANIM_PINGPONG_EN
  localparam logic [4:0]     LAST_M1  = 5'(LAST_FRAME - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [4:0]    frame_nxt;
  logic          tick_nxt, done_nxt, busy_nxt;
  logic          advance;
  logic          at_last;
  logic          finish;
`ifdef LED_ANIM_PINGPONG_EN
  logic          dir_up, dir_up_nxt;
`endif

  // The prescaler only counts in RUN, or on the cycle PAUSE is released, and
  // never on a cycle where start or stop takes over.
  assign advance = (state == RUN || state == PAUSE) && !pause && !stop && !start;
  assign at_last = (frame == LAST);
`ifdef LED_ANIM_PINGPONG_EN
  assign finish  = advance && (pre == PRE_MAX) && at_last && !loop_en && dir_up;
`else
  assign finish  = advance && (pre == PRE_MAX) && at_last && !loop_en;
`endif

  // State register and all registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pre        <= '0;
      frame      <= '0;
      frame_tick <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
      dir_up     <= 1'b1;
`endif
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      frame      <= frame_nxt;
      frame_tick <= tick_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
`ifdef LED_ANIM_PINGPONG_EN
      dir_up     <= dir_up_nxt;
`endif
    end
  end

  // Next-state logic: stop beats start, start beats pause.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN, PAUSE: begin
          if (pause)       state_nxt = PAUSE;
          else if (finish) state_nxt = DONE;
          else             state_nxt = RUN;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output logic: next values for the prescaler, frame index and pulses.
  always_comb begin
    pre_nxt    = pre;
    frame_nxt  = frame;
    tick_nxt   = 1'b0;
    done_nxt   = 1'b0;
    busy_nxt   = (state_nxt == RUN) || (state_nxt == PAUSE);
`ifdef LED_ANIM_PINGPONG_EN
    dir_up_nxt = dir_up;
`endif
    if (stop || start) begin
      pre_nxt    = '0;
      frame_nxt  = '0;
`ifdef LED_ANIM_PINGPONG_EN
      dir_up_nxt = 1'b1;
`endif
    end else if (advance) begin
      if (pre != PRE_MAX) begin
        pre_nxt = pre + PW'(1);
      end else begin
        pre_nxt = '0;
        if (finish) begin
          // One-shot end: hold the last frame and flag completion instead.
          done_nxt = 1'b1;
        end else begin
          tick_nxt = 1'b1;
`ifdef LED_ANIM_PINGPONG_EN
          if (dir_up) begin
            if (at_last) begin
              frame_nxt  = LAST_M1;
              dir_up_nxt = 1'b0;
            end else begin
              frame_nxt  = frame + 5'd1;
            end
          end else begin
            if (frame == 5'd0) begin
              frame_nxt  = 5'd1;
              dir_up_nxt = 1'b1;
            end else begin
              frame_nxt  = frame - 5'd1;
            end
          end
`else
          frame_nxt = at_last ? 5'd0 : frame + 5'd1;
`endif
        end
      end
    end
  end

endmodule
